// File: rtl/mem_write_buffer.sv
// mem_write_buffer: store buffer in front of a single-cycle dual-port memory.
// CPU writes are queued in a small circular FIFO and drained one per cycle
// into the memory write port. CPU reads go straight to the memory read port
// and are kept coherent with writes still waiting in the buffer.
// Optional feature macro: MEM_WB_FORWARD_EN
//   defined   - read hits are forwarded from the youngest matching entry
//   undefined - read hits stall the CPU until the matching entries drain
module mem_write_buffer #(
    parameter int unsigned width = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             cpu_wr_valid,
    input  logic [15:0]      cpu_wr_addr,
    input  logic [width-1:0] cpu_wr_data,
    output logic             cpu_wr_ready,
    input  logic             cpu_rd_en,
    input  logic [15:0]      cpu_rd_addr,
    output logic             cpu_rd_stall,
    output logic             cpu_rd_valid,
    output logic [width-1:0] cpu_rd_data,
    input  logic             hold,
    output logic             empty,
    output logic             full,
    output logic [15:0]      mem_wraddress,
    output logic             mem_wren,
    output logic [width-1:0] mem_data,
    output logic [15:0]      mem_rdaddress,
    input  logic [width-1:0] mem_q
);

    localparam int unsigned AW = 16;
    localparam int unsigned PW = $clog2(DEPTH);

    // Buffer storage and FIFO bookkeeping
    logic [AW-1:0]    addr_q [DEPTH];
    logic [width-1:0] data_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             rd_valid_q, rd_valid_d;

    logic             push;
    logic             drain;
    logic             hit;
    logic             rd_accept;
    logic [PW-1:0]    idx;

`ifdef MEM_WB_FORWARD_EN
    logic             fwd_hit_q, fwd_hit_d;
    logic [width-1:0] fwd_data_q, fwd_data_d;
    logic [width-1:0] hit_data;
`endif

    // Flags come straight from the registered count, so they are glitch-free
    assign empty        = (count_q == '0);
    assign full         = (count_q == (PW+1)'(DEPTH));
    assign cpu_wr_ready = !full;

    assign push  = cpu_wr_valid && !full;
    assign drain = !empty && !hold;

    assign mem_wren      = drain;
    assign mem_wraddress = drain ? addr_q[head_q] : '0;
    assign mem_data      = drain ? data_q[head_q] : '0;
    assign mem_rdaddress = cpu_rd_addr;

    // Next pointer/count state; push and pop in the same cycle cancel in the count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push)
            tail_d = tail_q + 1'b1;
        if (drain)
            head_d = head_q + 1'b1;
        if (push && !drain)
            count_d = count_q + 1'b1;
        else if (!push && drain)
            count_d = count_q - 1'b1;
    end

    // Hit check against start-of-cycle entries, walked oldest to youngest so the
    // last match (the youngest) wins; an entry pushed this cycle is not yet counted
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef MEM_WB_FORWARD_EN
        hit_data = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (((PW+1)'(k) < count_q) && (addr_q[idx] == cpu_rd_addr)) begin
                hit = 1'b1;
`ifdef MEM_WB_FORWARD_EN
                hit_data = data_q[idx];
`endif
            end
        end
    end

`ifdef MEM_WB_FORWARD_EN
    assign cpu_rd_stall = 1'b0;
    assign rd_accept    = cpu_rd_en;

    // Capture forwarded data for a read that hits the buffer
    always_comb begin
        fwd_hit_d  = cpu_rd_en && hit;
        fwd_data_d = fwd_data_q;
        if (cpu_rd_en && hit)
            fwd_data_d = hit_data;
    end

    // Forwarding registers
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign cpu_rd_data = rd_valid_q ? (fwd_hit_q ? fwd_data_q : mem_q) : '0;
`else
    assign cpu_rd_stall = cpu_rd_en && hit;
    assign rd_accept    = cpu_rd_en && !hit;
    assign cpu_rd_data  = rd_valid_q ? mem_q : '0;
`endif

    assign rd_valid_d   = rd_accept;
    assign cpu_rd_valid = rd_valid_q;

    // Pointer, count and read-valid state; reset discards pending entries
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Entry payload; only meaningful while counted, so no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= cpu_wr_addr;
            data_q[tail_q] <= cpu_wr_data;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with a behavioural dual-port memory.
// Works with MEM_WB_FORWARD_EN either defined or undefined.
module tb_mem_write_buffer;

  logic        clock;
  logic        aclr;
  logic        cpu_wr_valid;
  logic [15:0] cpu_wr_addr;
  logic [15:0] cpu_wr_data;
  logic        cpu_wr_ready;
  logic        cpu_rd_en;
  logic [15:0] cpu_rd_addr;
  logic        cpu_rd_stall;
  logic        cpu_rd_valid;
  logic [15:0] cpu_rd_data;
  logic        hold;
  logic        empty;
  logic        full;
  logic [15:0] mem_wraddress;
  logic        mem_wren;
  logic [15:0] mem_data;
  logic [15:0] mem_rdaddress;
  logic [15:0] mem_q;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [15:0] mem [65536];
  logic [15:0] log_a [$];
  logic [15:0] log_d [$];
  int          base;

  mem_write_buffer #(
    .width(16),
    .DEPTH(4)
  ) dut (
    .clock        (clock),
    .aclr         (aclr),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_en    (cpu_rd_en),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_stall (cpu_rd_stall),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data),
    .hold         (hold),
    .empty        (empty),
    .full         (full),
    .mem_wraddress(mem_wraddress),
    .mem_wren     (mem_wren),
    .mem_data     (mem_data),
    .mem_rdaddress(mem_rdaddress),
    .mem_q        (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: registered read (old data on collision), logged writes
  always @(posedge clock) begin
    mem_q <= mem[mem_rdaddress];
    if (mem_wren) begin
      mem[mem_wraddress] <= mem_data;
      log_a.push_back(mem_wraddress);
      log_d.push_back(mem_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input bit ok);
    total++;
    if (ok) passed++;
    else begin
      failed++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_wait(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    cpu_rd_en   = 1'b1;
    cpu_rd_addr = addr;
    #1;
    while (cpu_rd_stall && n < 10) begin
      step();
      n++;
    end
    check({tag, "_stall_bound"}, n < 10);
    step();
    cpu_rd_en = 1'b0;
    #1;
    check({tag, "_valid"}, cpu_rd_valid === 1'b1);
    check({tag, "_data"}, cpu_rd_data === exp);
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    #1;
    while (!empty && n < 10) begin
      step();
      n++;
    end
    check(tag, empty === 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0020] = 16'h00AA;
    aclr = 1'b0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr  = '0;
    cpu_wr_data  = '0;
    cpu_rd_en    = 1'b0;
    cpu_rd_addr  = '0;
    hold         = 1'b0;

    // Reset state
    #2;
    check("rst_empty", empty === 1'b1);
    check("rst_full", full === 1'b0);
    check("rst_ready", cpu_wr_ready === 1'b1);
    check("rst_wren", mem_wren === 1'b0);
    check("rst_wraddr", mem_wraddress === 16'h0000);
    check("rst_rdvalid", cpu_rd_valid === 1'b0);
    check("rst_rddata", cpu_rd_data === 16'h0000);
    check("rst_stall", cpu_rd_stall === 1'b0);
    step();
    step();
    aclr = 1'b1;
    step();

    // Fill under hold: 4 accepted, 5th refused
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'(16'h0100 + i);
      cpu_wr_data  = 16'(16'hA000 + i);
      #1;
      check("fill_ready", cpu_wr_ready === (i < 4));
      check("fill_full", full === (i == 4));
      check("fill_hold_wren", mem_wren === 1'b0);
      step();
    end
    cpu_wr_valid = 1'b0;
    #1;
    check("fill_full_after", full === 1'b1);
    check("fill_ready_after", cpu_wr_ready === 1'b0);
    base = log_a.size();
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_wren", mem_wren === 1'b1);
      check("drain_addr", mem_wraddress === 16'(16'h0100 + k));
      check("drain_data", mem_data === 16'(16'hA000 + k));
      step();
    end
    #1;
    check("drain_empty", empty === 1'b1);
    check("drain_idle_wren", mem_wren === 1'b0);
    check("drain_idle_addr", mem_wraddress === 16'h0000);
    check("drain_idle_data", mem_data === 16'h0000);
    check("drain_log_count", log_a.size() == base + 4);
    for (int k = 0; k < 4; k++) begin
      check("drain_log_addr", log_a[base + k] === 16'(16'h0100 + k));
      check("drain_log_data", log_d[base + k] === 16'(16'hA000 + k));
    end

    // Two writes to one address under hold, then read it back
    hold = 1'b1;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 16'h0010;
    cpu_wr_data  = 16'h1111;
    step();
    cpu_wr_data  = 16'h2222;
    step();
    cpu_wr_valid = 1'b0;
    cpu_rd_en    = 1'b1;
    cpu_rd_addr  = 16'h0010;
    #1;
`ifdef MEM_WB_FORWARD_EN
    check("fwd_no_stall", cpu_rd_stall === 1'b0);
`else
    check("stall_hit", cpu_rd_stall === 1'b1);
    step();
    check("stall_hit_held", cpu_rd_stall === 1'b1);
    check("stall_no_valid", cpu_rd_valid === 1'b0);
    hold = 1'b0;
`endif
    read_wait(16'h0010, 16'h2222, "hit_rd");
    hold = 1'b0;
    wait_empty("hit_empty");

    // Same-cycle push and read of one address
    step();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 16'h0020;
    cpu_wr_data  = 16'h00BB;
    cpu_rd_en    = 1'b1;
    cpu_rd_addr  = 16'h0020;
    #1;
    check("same_no_stall", cpu_rd_stall === 1'b0);
    step();
    cpu_wr_valid = 1'b0;
    #1;
    check("same_valid", cpu_rd_valid === 1'b1);
    check("same_old_data", cpu_rd_data === 16'h00AA);
    read_wait(16'h0020, 16'h00BB, "next_rd");
    wait_empty("same_empty");

    // Wrap-around: steady push/pop at count 1
    step();
    base = log_a.size();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 16'h0200;
    cpu_wr_data  = 16'hC000;
    step();
    for (int i = 0; i < 10; i++) begin
      cpu_wr_addr = 16'(16'h0201 + i);
      cpu_wr_data = 16'(16'hC001 + i);
      #1;
      check("wrap_wren", mem_wren === 1'b1);
      check("wrap_addr", mem_wraddress === 16'(16'h0200 + i));
      check("wrap_not_empty", empty === 1'b0);
      check("wrap_not_full", full === 1'b0);
      step();
    end
    cpu_wr_valid = 1'b0;
    #1;
    check("wrap_last_addr", mem_wraddress === 16'h020A);
    step();
    check("wrap_empty", empty === 1'b1);
    check("wrap_log_count", log_a.size() == base + 11);
    for (int k = 0; k < 11; k++) begin
      check("wrap_log_addr", log_a[base + k] === 16'(16'h0200 + k));
      check("wrap_log_data", log_d[base + k] === 16'(16'hC000 + k));
    end

    // Reset in the cycle after the first drain
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'(16'h0300 + i);
      cpu_wr_data  = 16'(16'hD000 + i);
      step();
    end
    cpu_wr_valid = 1'b0;
    base = log_a.size();
    hold = 1'b0;
    #1;
    check("mid_first_addr", mem_wraddress === 16'h0300);
    step();
    aclr = 1'b0;
    #1;
    check("mid_rst_empty", empty === 1'b1);
    check("mid_rst_full", full === 1'b0);
    check("mid_rst_ready", cpu_wr_ready === 1'b1);
    check("mid_rst_wren", mem_wren === 1'b0);
    check("mid_rst_wraddr", mem_wraddress === 16'h0000);
    check("mid_rst_data", mem_data === 16'h0000);
    check("mid_rst_rdvalid", cpu_rd_valid === 1'b0);
    check("mid_rst_rddata", cpu_rd_data === 16'h0000);
    check("mid_rst_stall", cpu_rd_stall === 1'b0);
    step();
    aclr = 1'b1;
    step();
    step();
    check("mid_after_empty", empty === 1'b1);
    check("mid_after_wren", mem_wren === 1'b0);
    check("mid_log_count", log_a.size() == base + 1);
    check("mid_log_addr", log_a[base] === 16'h0300);
    check("mid_unwritten", mem[16'h0301] === 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
